// File: rtl/spimmc_pkg.sv
// Shared definitions for the SPI-mode MMC/SD command sequencer: FSM encoding,
// engine transfer-count codes and the serial CRC7 step.
package spimmc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CRC     = 3'd1,
    SEND_HI = 3'd2,
    SEND_LO = 3'd3,
    POLL    = 3'd4,
    DESEL   = 3'd5,
    DONE    = 3'd6
  } state_e;

  localparam logic [7:0]  CNT_READ     = 8'd0;
  localparam logic [7:0]  CNT_DESELECT = 8'd255;
  localparam logic [7:0]  CNT_HI       = 8'd32;
  localparam logic [7:0]  CNT_LO       = 8'd16;
  localparam logic [6:0]  CRC7_POLY    = 7'h09;
  localparam int unsigned FRAME_BITS   = 40;

  // One bit of CRC7 (x^7+x^3+1), message bit entering MSB-first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/spimmc_crc7.sv
// Serial CRC7 accumulator, one message bit per enabled cycle.
module spimmc_crc7
  import spimmc_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] r_crc;

  // CRC register: clear has priority over a new bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_crc <= 7'h00;
    end else if (clear) begin
      r_crc <= 7'h00;
    end else if (bit_valid) begin
      r_crc <= crc7_step(r_crc, bit_in);
    end else begin
      r_crc <= r_crc;
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/spimmc_cmd_seq.sv
// SD/MMC SPI-mode command sequencer: builds the 48-bit command frame with CRC7,
// drives it through the byte engine, polls for R1 and optionally deselects.
module spimmc_cmd_seq
  import spimmc_pkg::*;
#(
  parameter int unsigned NCR_MAX = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        cmd_keep_cs,
  output logic        resp_valid,
  output logic [7:0]  resp_r1,
  output logic        resp_timeout,
  output logic        mmc_valid,
  input  logic        mmc_ready,
  output logic [31:0] mmc_wdata,
  output logic [7:0]  mmc_wdata_cnt,
  input  logic [31:0] mmc_rdata
);

  localparam logic [7:0] LP_POLL_LAST = 8'(NCR_MAX - 1);
  localparam logic [5:0] LP_LAST_BIT  = 6'(FRAME_BITS - 1);

  state_e      r_state, w_state_nxt, w_after_poll;
  logic [5:0]  r_index, w_index_nxt;
  logic [31:0] r_arg, w_arg_nxt;
  logic        r_keep_cs, w_keep_cs_nxt;
  logic [5:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]  r_poll_cnt, w_poll_cnt_nxt;
  logic        r_mmc_valid, w_mmc_valid_nxt;
  logic [31:0] r_mmc_wdata, w_mmc_wdata_nxt;
  logic [7:0]  r_mmc_cnt, w_mmc_cnt_nxt;
  logic        r_cmd_ready, w_cmd_ready_nxt;
  logic        r_resp_valid, w_resp_valid_nxt;
  logic [7:0]  r_resp_r1, w_resp_r1_nxt;
  logic        r_resp_to, w_resp_to_nxt;
  logic        w_crc_clear, w_crc_bit_valid, w_crc_bit;
  logic [6:0]  w_crc;
  logic [FRAME_BITS-1:0] w_frame;

  assign w_frame      = {2'b01, r_index, r_arg};
  assign w_after_poll = r_keep_cs ? DONE : DESEL;

  spimmc_crc7 u_crc7 (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (w_crc_clear),
    .bit_valid (w_crc_bit_valid),
    .bit_in    (w_crc_bit),
    .crc       (w_crc)
  );

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_index      <= 6'd0;
      r_arg        <= 32'd0;
      r_keep_cs    <= 1'b0;
      r_bit_cnt    <= 6'd0;
      r_poll_cnt   <= 8'd0;
      r_mmc_valid  <= 1'b0;
      r_mmc_wdata  <= 32'd0;
      r_mmc_cnt    <= 8'd0;
      r_cmd_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_r1    <= 8'hFF;
      r_resp_to    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_index      <= w_index_nxt;
      r_arg        <= w_arg_nxt;
      r_keep_cs    <= w_keep_cs_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_poll_cnt   <= w_poll_cnt_nxt;
      r_mmc_valid  <= w_mmc_valid_nxt;
      r_mmc_wdata  <= w_mmc_wdata_nxt;
      r_mmc_cnt    <= w_mmc_cnt_nxt;
      r_cmd_ready  <= w_cmd_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_r1    <= w_resp_r1_nxt;
      r_resp_to    <= w_resp_to_nxt;
    end
  end

  // Next-state and next-output logic; each transfer state raises valid on its
  // first (gap) cycle and drops it on the handshake cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_index_nxt      = r_index;
    w_arg_nxt        = r_arg;
    w_keep_cs_nxt    = r_keep_cs;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_poll_cnt_nxt   = r_poll_cnt;
    w_mmc_valid_nxt  = r_mmc_valid;
    w_mmc_wdata_nxt  = r_mmc_wdata;
    w_mmc_cnt_nxt    = r_mmc_cnt;
    w_resp_valid_nxt = 1'b0;
    w_resp_r1_nxt    = r_resp_r1;
    w_resp_to_nxt    = r_resp_to;
    w_crc_clear      = 1'b0;
    w_crc_bit_valid  = 1'b0;
    w_crc_bit        = w_frame[LP_LAST_BIT - r_bit_cnt];

    case (r_state)
      IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_index_nxt    = cmd_index;
          w_arg_nxt      = cmd_arg;
          w_keep_cs_nxt  = cmd_keep_cs;
          w_bit_cnt_nxt  = 6'd0;
          w_poll_cnt_nxt = 8'd0;
          w_crc_clear    = 1'b1;
          w_state_nxt    = CRC;
        end else begin
          w_state_nxt    = IDLE;
        end
      end
      CRC: begin
        w_crc_bit_valid = 1'b1;
        if (r_bit_cnt == LP_LAST_BIT) begin
          w_mmc_valid_nxt = 1'b1;
          w_mmc_wdata_nxt = {2'b01, r_index, r_arg[31:8]};
          w_mmc_cnt_nxt   = CNT_HI;
          w_state_nxt     = SEND_HI;
        end else begin
          w_bit_cnt_nxt   = r_bit_cnt + 6'd1;
        end
      end
      SEND_HI: begin
        if (r_mmc_valid && mmc_ready) begin
          w_mmc_valid_nxt = 1'b0;
          w_state_nxt     = SEND_LO;
        end else begin
          w_mmc_valid_nxt = 1'b1;
        end
      end
      SEND_LO: begin
        if (!r_mmc_valid) begin
          w_mmc_valid_nxt = 1'b1;
          w_mmc_wdata_nxt = {r_arg[7:0], w_crc, 1'b1, 16'h0000};
          w_mmc_cnt_nxt   = CNT_LO;
        end else if (mmc_ready) begin
          w_mmc_valid_nxt = 1'b0;
          w_state_nxt     = POLL;
        end else begin
          w_mmc_valid_nxt = 1'b1;
        end
      end
      POLL: begin
        if (!r_mmc_valid) begin
          w_mmc_valid_nxt = 1'b1;
          w_mmc_wdata_nxt = 32'h0000_0000;
          w_mmc_cnt_nxt   = CNT_READ;
        end else if (mmc_ready) begin
          w_mmc_valid_nxt = 1'b0;
          if (!mmc_rdata[7]) begin
            w_resp_r1_nxt    = mmc_rdata[7:0];
            w_resp_to_nxt    = 1'b0;
            w_resp_valid_nxt = r_keep_cs;
            w_state_nxt      = w_after_poll;
          end else if (r_poll_cnt == LP_POLL_LAST) begin
            w_resp_r1_nxt    = 8'hFF;
            w_resp_to_nxt    = 1'b1;
            w_resp_valid_nxt = r_keep_cs;
            w_state_nxt      = w_after_poll;
          end else begin
            w_poll_cnt_nxt   = r_poll_cnt + 8'd1;
          end
        end else begin
          w_mmc_valid_nxt = 1'b1;
        end
      end
      DESEL: begin
        if (!r_mmc_valid) begin
          w_mmc_valid_nxt = 1'b1;
          w_mmc_wdata_nxt = 32'h0000_0000;
          w_mmc_cnt_nxt   = CNT_DESELECT;
        end else if (mmc_ready) begin
          w_mmc_valid_nxt  = 1'b0;
          w_resp_valid_nxt = 1'b1;
          w_state_nxt      = DONE;
        end else begin
          w_mmc_valid_nxt  = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_mmc_valid_nxt = 1'b0;
        w_state_nxt     = IDLE;
      end
    endcase

    w_cmd_ready_nxt = (w_state_nxt == IDLE);
  end

  assign cmd_ready     = r_cmd_ready;
  assign resp_valid    = r_resp_valid;
  assign resp_r1       = r_resp_r1;
  assign resp_timeout  = r_resp_to;
  assign mmc_valid     = r_mmc_valid;
  assign mmc_wdata     = r_mmc_wdata;
  assign mmc_wdata_cnt = r_mmc_cnt;

endmodule
